// File: rtl/universal_register_pkg.sv
// Shared op-code definitions for universal_register and the FSMs that drive it.
package universal_register_pkg;

  localparam int unsigned OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NONE = 3'd0,
    OP_LOAD = 3'd1,
    OP_INCR = 3'd2,
    OP_DECR = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

endpackage

// File: rtl/universal_register_if.sv
// Control/data bundle between a controlling FSM (master) and universal_register (slave).
interface universal_register_if
  import universal_register_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [OP_WIDTH-1:0] ctrl;
  logic [WIDTH-1:0]    data_in;
  logic                serial_in;
  logic [WIDTH-1:0]    data_out;
  logic                serial_out;
  logic                carry;
  logic                borrow;
  logic                zero;
  logic                tc;

  modport master (
    output ctrl, data_in, serial_in,
    input  data_out, serial_out, carry, borrow, zero, tc
  );

  modport slave (
    input  ctrl, data_in, serial_in,
    output data_out, serial_out, carry, borrow, zero, tc
  );

endinterface

// File: rtl/universal_register_mod_step.sv
// Modulo increment/decrement step with limit detection (wrap or saturate).
module universal_register_mod_step #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_incr,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_decr,
  output logic             o_borrow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // Increment: any value at or above the limit counts as hitting it.
  always_comb begin
    o_incr  = i_data + ONE;
    o_carry = 1'b0;
    if (i_data >= MAX_V) begin
      o_carry = 1'b1;
      o_incr  = SATURATE ? MAX_V : '0;
    end
  end

  // Decrement: only zero is a limit event; out-of-range values (left by shifts) snap to the limit.
  always_comb begin
    o_decr   = i_data - ONE;
    o_borrow = 1'b0;
    if (i_data == '0) begin
      o_borrow = 1'b1;
      o_decr   = SATURATE ? '0 : MAX_V;
    end else if (i_data > MAX_V) begin
      o_decr = MAX_V;
    end
  end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit register: load, modulo up/down count, shift/rotate, clear, with carry/borrow pulses.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = (2**WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                clk,
  input  logic                async_nreset,
  universal_register_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] r_data;
  logic             r_serial;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH-1:0] w_data_nxt;
  logic             w_serial_nxt;
  logic             w_carry_nxt;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_incr;
  logic [WIDTH-1:0] w_decr;
  logic             w_step_carry;
  logic             w_step_borrow;
  op_e              w_op;

  assign w_op = op_e'(bus.ctrl);

  universal_register_mod_step #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE),
    .SATURATE  (SATURATE)
  ) u_mod_step (
    .i_data   (r_data),
    .o_incr   (w_incr),
    .o_carry  (w_step_carry),
    .o_decr   (w_decr),
    .o_borrow (w_step_borrow)
  );

  // Operation mux: default holds data/serial_out and drops carry/borrow.
  always_comb begin
    w_data_nxt   = r_data;
    w_serial_nxt = r_serial;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    case (w_op)
      OP_NONE: ;
      OP_LOAD: w_data_nxt = (bus.data_in > MAX_V) ? MAX_V : bus.data_in;
      OP_INCR: begin
        w_data_nxt  = w_incr;
        w_carry_nxt = w_step_carry;
      end
      OP_DECR: begin
        w_data_nxt   = w_decr;
        w_borrow_nxt = w_step_borrow;
      end
      OP_SHL: begin
        w_data_nxt   = {r_data[WIDTH-2:0], bus.serial_in};
        w_serial_nxt = r_data[WIDTH-1];
      end
      OP_SHR: begin
        w_data_nxt   = {bus.serial_in, r_data[WIDTH-1:1]};
        w_serial_nxt = r_data[0];
      end
      OP_ROL: begin
        w_data_nxt   = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_serial_nxt = r_data[WIDTH-1];
      end
      OP_CLR: begin
        w_data_nxt   = '0;
        w_serial_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_data   <= '0;
      r_serial <= 1'b0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_data   <= w_data_nxt;
      r_serial <= w_serial_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign bus.data_out   = r_data;
  assign bus.serial_out = r_serial;
  assign bus.carry      = r_carry;
  assign bus.borrow     = r_borrow;
  assign bus.zero       = (r_data == '0);
  assign bus.tc         = (r_data == MAX_V);

endmodule

// File: tb/tb_universal_register.sv
// Directed bench: three configurations (wrap MAX=9, saturate MAX=9, default full range).
module tb_universal_register;
  import universal_register_pkg::*;

  logic clk;
  logic async_nreset;
  int   checks;
  int   errors;

  universal_register_if #(.WIDTH(8)) bw ();
  universal_register_if #(.WIDTH(8)) bs ();
  universal_register_if #(.WIDTH(8)) bd ();

  universal_register #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .async_nreset(async_nreset), .bus(bw));
  universal_register #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .async_nreset(async_nreset), .bus(bs));
  universal_register #(.WIDTH(8), .MAX_VALUE(255), .SATURATE(1'b0)) u_def (
    .clk(clk), .async_nreset(async_nreset), .bus(bd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 = wrap, 1 = saturate, 2 = default
  task automatic drive(input int which, input op_e op, input logic [7:0] din, input logic si);
    case (which)
      0: begin bw.ctrl = op; bw.data_in = din; bw.serial_in = si; end
      1: begin bs.ctrl = op; bs.data_in = din; bs.serial_in = si; end
      default: begin bd.ctrl = op; bd.data_in = din; bd.serial_in = si; end
    endcase
  endtask

  task automatic step(input int which, input op_e op, input logic [7:0] din, input logic si);
    drive(which, op, din, si);
    @(posedge clk);
    #1;
    drive(which, OP_NONE, 8'h00, 1'b0);
  endtask

  task automatic check_state(input int which, input string tag, input logic [7:0] d,
                             input logic c, input logic b, input logic so);
    logic [7:0] got_d;
    logic [7:0] maxv;
    logic       got_c, got_b, got_so, got_z, got_tc;
    case (which)
      0: begin got_d = bw.data_out; got_c = bw.carry; got_b = bw.borrow;
               got_so = bw.serial_out; got_z = bw.zero; got_tc = bw.tc; maxv = 8'd9; end
      1: begin got_d = bs.data_out; got_c = bs.carry; got_b = bs.borrow;
               got_so = bs.serial_out; got_z = bs.zero; got_tc = bs.tc; maxv = 8'd9; end
      default: begin got_d = bd.data_out; got_c = bd.carry; got_b = bd.borrow;
               got_so = bd.serial_out; got_z = bd.zero; got_tc = bd.tc; maxv = 8'd255; end
    endcase
    chk({tag, ".data"},   32'(got_d),  32'(d));
    chk({tag, ".carry"},  32'(got_c),  32'(c));
    chk({tag, ".borrow"}, 32'(got_b),  32'(b));
    chk({tag, ".sout"},   32'(got_so), 32'(so));
    chk({tag, ".zero"},   32'(got_z),  32'(d == 8'd0));
    chk({tag, ".tc"},     32'(got_tc), 32'(d == maxv));
  endtask

  initial begin
    logic [7:0] exp_d;
    checks = 0;
    errors = 0;
    async_nreset = 1'b0;
    drive(0, OP_INCR, 8'h00, 1'b1);
    drive(1, OP_LOAD, 8'h07, 1'b1);
    drive(2, OP_SHL,  8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_state(0, "rst_wrap", 8'd0, 1'b0, 1'b0, 1'b0);
    check_state(1, "rst_sat",  8'd0, 1'b0, 1'b0, 1'b0);
    check_state(2, "rst_def",  8'd0, 1'b0, 1'b0, 1'b0);
    drive(0, OP_NONE, 8'h00, 1'b0);
    drive(1, OP_NONE, 8'h00, 1'b0);
    drive(2, OP_NONE, 8'h00, 1'b0);
    @(negedge clk);
    async_nreset = 1'b1;

    // wrap counting 1..9,0
    for (int i = 1; i <= 10; i++) begin
      exp_d = 8'(i % 10);
      step(0, OP_INCR, 8'h00, 1'b0);
      check_state(0, $sformatf("incr%0d", i), exp_d, (i == 10), 1'b0, 1'b0);
    end
    step(0, OP_DECR, 8'h00, 1'b0);
    check_state(0, "decr_wrap", 8'd9, 1'b0, 1'b1, 1'b0);
    step(0, OP_LOAD, 8'd200, 1'b0);
    check_state(0, "load_clamp", 8'd9, 1'b0, 1'b0, 1'b0);
    step(0, OP_INCR, 8'h00, 1'b0);
    check_state(0, "incr_top", 8'd0, 1'b1, 1'b0, 1'b0);
    step(0, OP_NONE, 8'h00, 1'b0);
    check_state(0, "hold", 8'd0, 1'b0, 1'b0, 1'b0);

    // saturating limits
    step(1, OP_LOAD, 8'd9, 1'b0);
    check_state(1, "sat_load", 8'd9, 1'b0, 1'b0, 1'b0);
    step(1, OP_INCR, 8'h00, 1'b0);
    check_state(1, "sat_incr1", 8'd9, 1'b1, 1'b0, 1'b0);
    step(1, OP_INCR, 8'h00, 1'b0);
    check_state(1, "sat_incr2", 8'd9, 1'b1, 1'b0, 1'b0);
    step(1, OP_CLR, 8'h00, 1'b0);
    check_state(1, "sat_clr", 8'd0, 1'b0, 1'b0, 1'b0);
    step(1, OP_DECR, 8'h00, 1'b0);
    check_state(1, "sat_decr", 8'd0, 1'b0, 1'b1, 1'b0);

    // shifts on full-range register
    step(2, OP_LOAD, 8'hA5, 1'b0);
    check_state(2, "def_load", 8'hA5, 1'b0, 1'b0, 1'b0);
    step(2, OP_SHL, 8'h00, 1'b1);
    check_state(2, "def_shl", 8'h4B, 1'b0, 1'b0, 1'b1);
    step(2, OP_SHR, 8'h00, 1'b0);
    check_state(2, "def_shr", 8'h25, 1'b0, 1'b0, 1'b1);
    step(2, OP_NONE, 8'h00, 1'b0);
    check_state(2, "def_hold", 8'h25, 1'b0, 1'b0, 1'b1);
    step(2, OP_ROL, 8'h00, 1'b1);
    check_state(2, "def_rol", 8'h4A, 1'b0, 1'b0, 1'b0);
    step(2, OP_LOAD, 8'hFF, 1'b0);
    step(2, OP_INCR, 8'h00, 1'b0);
    check_state(2, "def_wrap", 8'h00, 1'b1, 1'b0, 1'b0);

    // shift past the limit, then count back into range
    step(0, OP_LOAD, 8'd8, 1'b0);
    step(0, OP_SHL, 8'h00, 1'b0);
    check_state(0, "shl_over", 8'd16, 1'b0, 1'b0, 1'b0);
    step(0, OP_DECR, 8'h00, 1'b0);
    check_state(0, "decr_over", 8'd9, 1'b0, 1'b0, 1'b0);
    step(0, OP_INCR, 8'h00, 1'b0);
    check_state(0, "incr_after", 8'd0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a count
    step(0, OP_LOAD, 8'd3, 1'b0);
    step(0, OP_SHR, 8'h00, 1'b0);
    check_state(0, "pre_shr", 8'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(0, OP_INCR, 8'h00, 1'b0);
    check_state(0, "pre_rst", 8'd5, 1'b0, 1'b0, 1'b1);
    drive(0, OP_INCR, 8'h00, 1'b0);
    #2;
    async_nreset = 1'b0;
    #1;
    check_state(0, "mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    async_nreset = 1'b1;
    @(posedge clk);
    #1;
    drive(0, OP_NONE, 8'h00, 1'b0);
    check_state(0, "post_rst", 8'd1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised successor to the team's 2-bit-control parallel register: one WIDTH-bit register with parallel load, modulo up/down counting (wrap or saturate), serial shift left/right and clear, plus registered carry/borrow pulses and status flags. Used as a general datapath register, decade/modulo counter or serialiser in the lab designs; ctrl is driven directly by a controlling FSM each cycle.

## Interface
- WIDTH, 8, register width in bits (≥2)
- MAX_VALUE, 2**WIDTH-1, counting limit; count range 0..MAX_VALUE (1 ≤ MAX_VALUE ≤ 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- clk  input  1  clock, rising edge
- async_nreset  input  1  reset, asynchronous, active-low
- ctrl  input  3  operation select, sampled every rising edge
- data_in  input  WIDTH  parallel load value
- serial_in  input  1  bit shifted into the vacated position
- data_out  output  WIDTH  register contents
- serial_out  output  1  registered: last bit shifted out
- carry  output  1  registered one-cycle pulse: INCR hit upper limit
- borrow  output  1  registered one-cycle pulse: DECR hit lower limit
- zero  output  1  data_out == 0 (combinational from register)
- tc  output  1  data_out == MAX_VALUE (combinational from register)

## Operation
- ctrl codes: 0 NONE (hold), 1 LOAD, 2 INCR, 3 DECR, 4 SHL, 5 SHR, 6 ROL, 7 CLR.
- LOAD: data_in > MAX_VALUE loads MAX_VALUE (clamp); otherwise data_in.
- INCR: data < MAX_VALUE → data+1. data ≥ MAX_VALUE → 0 (wrap) or MAX_VALUE (saturate); carry=1 next cycle in both modes.
- DECR: 0 < data ≤ MAX_VALUE → data-1. data == 0 → MAX_VALUE (wrap) or 0 (saturate); borrow=1. data > MAX_VALUE (reachable only by shifts) → MAX_VALUE, no borrow.
- SHL: {data[WIDTH-2:0], serial_in}; serial_out ← data[WIDTH-1]. No clamping; result may exceed MAX_VALUE.
- SHR: {serial_in, data[WIDTH-1:1]}; serial_out ← data[0]. No clamping.
- ROL: {data[WIDTH-2:0], data[WIDTH-1]}; serial_out ← data[WIDTH-1]; serial_in ignored.
- CLR: data ← 0; serial_out ← 0.
- NONE: all registers hold except carry/borrow.
- carry and borrow are 0 on every cycle not following a limit event; never both 1.
- serial_out holds its value through non-shift operations other than CLR.
- All arithmetic in WIDTH bits; MAX_VALUE compare is unsigned.

## Timing
- Single-cycle: operation sampled at edge N appears on data_out, serial_out, carry, borrow after edge N.
- zero, tc follow data_out combinationally (no extra latency).
- Reset (any time, including mid-count or mid-shift): data_out=0, serial_out=0, carry=0, borrow=0 immediately; hence zero=1, tc=0 (tc=1 impossible since MAX_VALUE ≥ 1). First operation executes on first rising edge after deassertion.
- No handshake; ctrl valid every cycle, no illegal codes.

## Structure
- Shared package: 3-bit op-code constants (OP_NONE..OP_CLR), used by controlling FSMs.
- One combinational sub-module natural: mod_step (WIDTH, MAX_VALUE, SATURATE) computing next INCR/DECR value and carry/borrow; main module holds op mux and registers.

## Test plan
- WIDTH=8, MAX_VALUE=9, SATURATE=0: reset, 10×INCR → 1..9,0; carry high only the cycle data_out returns to 0; tc high while data_out=9.
- Same config: from 0, DECR → 9 with borrow pulse; LOAD 200 → 9 (clamped); INCR → 0, carry=1.
- SATURATE=1, MAX_VALUE=9: LOAD 9, INCR ×2 → stays 9, carry pulses each cycle; CLR, DECR → 0, borrow=1.
- WIDTH=8 default: LOAD 8'hA5, SHL serial_in=1 → 8'h4B, serial_out=1; SHR serial_in=0 → 8'h25, serial_out=1; ROL → 8'h4A, serial_out=0.
- MAX_VALUE=9: LOAD 8, SHL serial_in=0 → 16; DECR → 9, borrow=0; INCR → 0, carry=1.
- Assert async_nreset mid-INCR sequence (data 5) between edges → outputs 0 immediately, zero=1; release, INCR → 1.
